seg_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment display driver, successor to the fixed 4-digit two-field scanner. It converts a single binary value to BCD with an iterative double-dabble converter, then time-multiplexes up to 8 common-cathode digits. It also provides decimal points, overflow indication and optional leading-zero blanking. It sits between the application datapath (timers, counters, price registers) and the board digit/segment pins.

---
 rtl/seg_scan_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Multiplexed common-cathode 7-segment driver. A free-running
//               double-dabble converter turns the binary value into BCD and
//               commits it to display registers once per conversion period
//               (VAL_W+2 cycles). A prescaled index then scans N_DIGITS
//               positions. Select, segments and decimal point are all
//               registered in one stage, so they never skew.
//               Optional build macro: SEG_LZB_EN (leading-zero blanking).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int N_DIGITS = 4,   // digits scanned, 2..8
  parameter int VAL_W    = 14,  // binary input width, 1..27
  parameter int SCAN_DIV = 2    // clock cycles each digit is held, >= 1
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                en,
  input  logic [VAL_W-1:0]    value,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic [N_DIGITS-1:0] dig_pos,
  output logic [6:0]          dig_sec,
  output logic                dig_dp,
  output logic                conv_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_BCD_W = 4 * N_DIGITS;
  // Counter widths are kept at least one bit so degenerate parameter values
  // (VAL_W = 1, SCAN_DIV = 1) still elaborate cleanly.
  localparam int c_CNT_W = (VAL_W > 1)    ? $clog2(VAL_W)    : 1;
  localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IDX_W = $clog2(N_DIGITS);

  localparam logic [c_CNT_W-1:0]  c_SHIFT_LAST = c_CNT_W'(VAL_W - 1);
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST   = c_PRE_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST   = c_IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] c_POS_ONE    = N_DIGITS'(1);

  localparam logic [6:0] c_SEG_DASH  = 7'b1000000;
  localparam logic [6:0] c_SEG_BLANK = 7'b0000000;

  // --------------------------------------------------------------------------
  // Segment decode, {g,f,e,d,c,b,a}; non-decimal nibbles are dark
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = c_SEG_BLANK;
    endcase
    return seg;
  endfunction

  // --------------------------------------------------------------------------
  // Converter state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [VAL_W-1:0]    r_bin;        // binary shift register, MSB first
  logic [c_BCD_W-1:0]  r_bcd;        // BCD work register
  logic                r_ovf;        // a 1 fell off the top nibble
  logic [c_CNT_W-1:0]  r_cnt;        // shift step counter
  logic [c_BCD_W-1:0]  r_disp;       // committed BCD shown by the scanner
  logic                r_disp_ovf;   // committed overflow flag
  logic                r_conv_done;

  logic [c_BCD_W-1:0]  w_bcd_adj;
  logic [c_BCD_W:0]    w_bcd_shift;

  // Double-dabble correction: any nibble >= 5 gets +3 ahead of the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Top bit is the one shifted out of the most significant nibble
  assign w_bcd_shift = {w_bcd_adj, r_bin[VAL_W-1]};

  // Converter FSM: LOAD -> SHIFT x VAL_W -> COMMIT, free-running
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_disp      <= '0;
      r_disp_ovf  <= 1'b0;
      r_conv_done <= 1'b0;
    end else begin
      r_conv_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_bin   <= value;
          r_bcd   <= '0;
          r_ovf   <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_shift[c_BCD_W-1:0];
          r_bin <= r_bin << 1;
          // Sticky: once the result exceeds the digit count it stays invalid
          if (w_bcd_shift[c_BCD_W]) begin
            r_ovf <= 1'b1;
          end
          if (r_cnt == c_SHIFT_LAST) begin
            r_state <= ST_COMMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_disp      <= r_bcd;
          r_disp_ovf  <= r_ovf;
          r_conv_done <= 1'b1;
          r_state     <= ST_LOAD;
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign conv_done = r_conv_done;

  // --------------------------------------------------------------------------
  // Scan counter
  // --------------------------------------------------------------------------
  logic [c_PRE_W-1:0] r_pre;
  logic [c_IDX_W-1:0] r_idx;

  // Prescaler holds each position SCAN_DIV cycles, then steps the index
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == c_PRE_LAST) begin
      r_pre <= '0;
      r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-position digit view: position 0 is the most significant BCD digit
  // --------------------------------------------------------------------------
  logic [3:0] w_pos_nib [N_DIGITS];

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_pos_nib
    assign w_pos_nib[i] = r_disp[4*(N_DIGITS-1-i) +: 4];
  end

  logic w_blank;

`ifdef SEG_LZB_EN
  logic [N_DIGITS-1:0] w_lead_zero;

  // w_lead_zero[i]: positions 0..i are all zero digits
  always_comb begin
    w_lead_zero    = '0;
    w_lead_zero[0] = (w_pos_nib[0] == 4'd0);
    for (int i = 1; i < N_DIGITS; i++) begin
      w_lead_zero[i] = w_lead_zero[i-1] && (w_pos_nib[i] == 4'd0);
    end
  end

  // The rightmost position always shows a digit so zero reads as "0";
  // overflow dashes take precedence over blanking.
  assign w_blank = w_lead_zero[r_idx] && (r_idx != c_IDX_LAST) && !r_disp_ovf;
`else
  assign w_blank = 1'b0;
`endif

  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic [N_DIGITS-1:0] w_pos;

  // Segment pattern for the position currently indexed
  always_comb begin
    w_nib = w_pos_nib[r_idx];
    if (r_disp_ovf) begin
      w_seg = c_SEG_DASH;
    end else if (w_blank) begin
      w_seg = c_SEG_BLANK;
    end else begin
      w_seg = f_seg_decode(w_nib);
    end
  end

  assign w_pos = c_POS_ONE << r_idx;

  // --------------------------------------------------------------------------
  // Output stage: select, segments and dp registered together
  // --------------------------------------------------------------------------
  logic [N_DIGITS-1:0] r_dig_pos;
  logic [6:0]          r_dig_sec;
  logic                r_dig_dp;

  // Register one coherent position per cycle; en low darkens everything
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_pos <= '0;
      r_dig_sec <= '0;
      r_dig_dp  <= 1'b0;
    end else if (!en) begin
      r_dig_pos <= '0;
      r_dig_sec <= '0;
      r_dig_dp  <= 1'b0;
    end else begin
      r_dig_pos <= w_pos;
      r_dig_sec <= w_seg;
      r_dig_dp  <= dp_mask[r_idx];
    end
  end

  assign dig_pos = r_dig_pos;
  assign dig_sec = r_dig_sec;
  assign dig_dp  = r_dig_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed self-checking bench for seg_scan_driver at default
//               parameters (4 digits, 14-bit value, scan divider 2).
//               Expectations depending on SEG_LZB_EN follow the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int N_DIGITS = 4;
  localparam int VAL_W    = 14;
  localparam int SCAN_DIV = 2;

  // Hand-written segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1101111;
  localparam logic [6:0] SD = 7'b1000000;
`ifdef SEG_LZB_EN
  localparam logic [6:0] LZ = 7'b0000000;   // leading zero is blanked
`else
  localparam logic [6:0] LZ = 7'b0111111;   // leading zero shown as "0"
`endif

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [VAL_W-1:0]    value;
  logic [N_DIGITS-1:0] dp_mask;
  logic [N_DIGITS-1:0] dig_pos;
  logic [6:0]          dig_sec;
  logic                dig_dp;
  logic                conv_done;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .N_DIGITS (N_DIGITS),
    .VAL_W    (VAL_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .value     (value),
    .dp_mask   (dp_mask),
    .dig_pos   (dig_pos),
    .dig_sec   (dig_sec),
    .dig_dp    (dig_dp),
    .conv_done (conv_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the conv_done pulse (bounded) and checks the cycle count to it
  task automatic wait_conv(input string tag, input int exp_n);
    int n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (conv_done === 1'b1) begin
        n    = i;
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
  endtask

  // Called right after a conv_done: checks one full 8-cycle frame.
  // segs packs positions 0..3 left to right.
  task automatic frame(input string tag, input logic [27:0] segs, input logic [3:0] dpm);
    logic [3:0] ep;
    logic [6:0] es;
    int p;
    for (int k = 0; k < 8; k++) begin
      p  = k / 2;
      ep = 4'b0001 << p;
      es = segs[27-7*p -: 7];
      tick();
      if (k == 0) chk({tag, "_done_pulse"}, 32'(conv_done), 32'd0);
      chk($sformatf("%s_pos_c%0d", tag, k), 32'(dig_pos), 32'(ep));
      chk($sformatf("%s_seg_c%0d", tag, k), 32'(dig_sec), 32'(es));
      chk($sformatf("%s_dp_c%0d",  tag, k), 32'(dig_dp),  32'(dpm[p]));
    end
  endtask

  // From mid-SHIFT: new value is loaded at the next LOAD, shown after 2nd commit
  task automatic settle(input string tag, input logic [VAL_W-1:0] v);
    value = v;
    wait_conv({tag, "_a"}, 8);
    wait_conv({tag, "_b"}, 16);
  endtask

  initial begin
    rst_n   = 1'b1;
    en      = 1'b1;
    value   = 14'd1234;
    dp_mask = 4'b0000;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pos",  32'(dig_pos),   32'd0);
    chk("rst_sec",  32'(dig_sec),   32'd0);
    chk("rst_dp",   32'(dig_dp),    32'd0);
    chk("rst_done", 32'(conv_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_pos",  32'(dig_pos),   32'd0);
    chk("rst_hold_sec",  32'(dig_sec),   32'd0);
    chk("rst_hold_done", 32'(conv_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First commit 16 cycles after release; that edge still shows the
    // cleared display at the last position.
    wait_conv("first", 16);
    chk("first_pos", 32'(dig_pos), 32'(4'b1000));
    chk("first_sec", 32'(dig_sec), 32'(S0));
    chk("first_dp",  32'(dig_dp),  32'd0);

    frame("v1234", {S1, S2, S3, S4}, 4'b0000);

    // Change mid-SHIFT: the in-flight conversion still commits 1234
    value = 14'd5678;
    wait_conv("mid_a", 8);
    frame("hold1234", {S1, S2, S3, S4}, 4'b0000);
    wait_conv("mid_b", 8);
    frame("v5678", {S5, S6, S7, S8}, 4'b0000);

    // Overflow boundary; dp still follows the mask
    dp_mask = 4'b1001;
    settle("ovf", 14'd10000);
    frame("ovf", {SD, SD, SD, SD}, 4'b1001);
    dp_mask = 4'b0000;

    settle("v9999", 14'd9999);
    frame("v9999", {S9, S9, S9, S9}, 4'b0000);

    settle("v7", 14'd7);
    frame("v7", {LZ, LZ, LZ, S7}, 4'b0000);

    settle("v0", 14'd0);
    frame("v0", {LZ, LZ, LZ, S0}, 4'b0000);

    dp_mask = 4'b0100;
    settle("dp", 14'd1234);
    frame("dp", {S1, S2, S3, S4}, 4'b0100);

    // Enable dropped for 5 cycles; scan keeps running underneath
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("en_off_pos_c%0d", k), 32'(dig_pos), 32'd0);
      chk($sformatf("en_off_sec_c%0d", k), 32'(dig_sec), 32'd0);
      chk($sformatf("en_off_dp_c%0d",  k), 32'(dig_dp),  32'd0);
    end
    en = 1'b1;
    tick();
    chk("en_on_pos0", 32'(dig_pos), 32'(4'b0100));
    chk("en_on_sec0", 32'(dig_sec), 32'(S3));
    chk("en_on_dp0",  32'(dig_dp),  32'd1);
    tick();
    chk("en_on_pos1", 32'(dig_pos), 32'(4'b1000));
    chk("en_on_sec1", 32'(dig_sec), 32'(S4));
    chk("en_on_dp1",  32'(dig_dp),  32'd0);
    tick();
    chk("en_on_pos2",  32'(dig_pos),   32'(4'b1000));
    chk("en_on_done2", 32'(conv_done), 32'd1);

    // Asynchronous reset in the middle of SHIFT, between clock edges
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pos",  32'(dig_pos),   32'd0);
    chk("arst_sec",  32'(dig_sec),   32'd0);
    chk("arst_dp",   32'(dig_dp),    32'd0);
    chk("arst_done", 32'(conv_done), 32'd0);
    value = 14'd5678;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_conv("arst_rel", 16);
    chk("arst_rel_pos", 32'(dig_pos), 32'(4'b1000));
    chk("arst_rel_sec", 32'(dig_sec), 32'(S0));
    chk("arst_rel_dp",  32'(dig_dp),  32'd0);
    frame("post_rst", {S5, S6, S7, S8}, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
